// File: rtl/cpu_sequencer.sv
// Fetch/execute phase sequencer with run/step/halt control, RAM-ready stretching and a wait watchdog.
// Latency: 2 cycles per instruction with zero RAM waits; each wait cycle adds one cycle to its phase.
// Backpressure: mem_ready low holds the current phase; WAIT_MAX consecutive low cycles trap to FAULT.
module cpu_sequencer #(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic             halt,
   input  logic             mem_op,
   input  logic             mem_ready,
   output logic             sm,
   output logic             cycle_en,
   output logic [2:0]       state,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_cnt
);

   // Wait counter only needs to reach WAIT_MAX-1; width 1 when the watchdog is off.
   localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALTED = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t          cur_st;
   state_t          nxt_st;
   logic            step_mode;
   logic [WC_W-1:0] wait_cnt;
   logic            need_ram;
   logic            phase_done;
   logic            wd_expire;
   logic            retire;

   // Phase qualifiers: does this phase wait on RAM, is it finishing, has the watchdog run out.
   always_comb begin
      need_ram   = 1'b0;
      phase_done = 1'b0;
      case (cur_st)
         S_FETCH: begin
            need_ram   = 1'b1;
            phase_done = mem_ready;
         end
         S_EXEC: begin
            // halt completes at once even for a RAM-touching opcode
            need_ram   = mem_op & ~halt;
            phase_done = halt | ~mem_op | mem_ready;
         end
         default: ;
      endcase
      wd_expire = (WAIT_MAX != 0) && need_ram && !mem_ready && (wait_cnt == WAIT_LAST);
      retire    = (cur_st == S_EXEC) && phase_done && !rst;
   end

   // State register and the bookkeeping that moves with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_st    <= S_IDLE;
         step_mode <= 1'b0;
         wait_cnt  <= '0;
         instr_cnt <= '0;
      end else begin
         cur_st <= nxt_st;
         if (cur_st == S_IDLE && (run || step))
            step_mode <= ~run;
         if (nxt_st != cur_st)
            wait_cnt <= '0;
         else if (need_ram && !mem_ready && wait_cnt != {WC_W{1'b1}})
            wait_cnt <= wait_cnt + 1'b1;
         if (retire)
            instr_cnt <= instr_cnt + 1'b1;
      end
   end

   // Next-state selection; watchdog expiry overrides normal phase progress.
   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         S_IDLE: begin
            if (run || step)
               nxt_st = S_FETCH;
         end
         S_FETCH: begin
            if (wd_expire)
               nxt_st = S_FAULT;
            else if (mem_ready)
               nxt_st = S_EXEC;
         end
         S_EXEC: begin
            if (wd_expire)
               nxt_st = S_FAULT;
            else if (phase_done) begin
               if (halt)
                  nxt_st = S_HALTED;
               else if (step_mode)
                  nxt_st = S_IDLE;
               else if (run)
                  nxt_st = S_FETCH;
               else
                  nxt_st = S_IDLE;
            end
         end
         S_HALTED: nxt_st = S_HALTED;
         S_FAULT:  nxt_st = S_FAULT;
         default:  nxt_st = S_IDLE;
      endcase
   end

   // Moore decodes plus the commit strobe; nothing commits on a reset cycle.
   always_comb begin
      state    = cur_st;
      sm       = (cur_st == S_EXEC);
      busy     = (cur_st == S_FETCH) || (cur_st == S_EXEC);
      halted   = (cur_st == S_HALTED);
      fault    = (cur_st == S_FAULT);
      cycle_en = !rst && (((cur_st == S_FETCH) && mem_ready) || retire);
   end

endmodule
